cdc_hs_tx_ctrl: RTL and testbench

Source-side controller for a toggle req/ack clock-domain-crossing handshake. It accepts one data word at a time over a valid/ready interface, holds it stable on the crossing bus, and toggles `xfer_req`. It then waits for the destination domain's `xfer_ack` toggle, which it synchronizes internally before releasing the bus for the next word. An optional timeout aborts a stalled transfer and realigns the handshake phase.

---
 rtl/cdc_hs_pkg.sv | 11 +
 rtl/cdc_hs_ack_sync.sv | 24 ++
 rtl/cdc_hs_tx_ctrl.sv | 151 +++++++++++++++
 tb/tb_cdc_hs_tx_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_hs_pkg.sv
// rtl/cdc_hs_pkg.sv - shared types for the toggle req/ack CDC source controller
package cdc_hs_pkg;

    // ABORT keeps its encoding even when the timeout logic is compiled out
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ABORT = 2'd2
    } cdc_hs_state_t;

endpackage

// File: rtl/cdc_hs_ack_sync.sv
// rtl/cdc_hs_ack_sync.sv - two-flop synchronizer for the destination ack toggle
module cdc_hs_ack_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic ack_s1_q;
    (* ASYNC_REG = "TRUE" *) logic ack_s_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_s1_q <= 1'b0;
            ack_s_q  <= 1'b0;
        end else begin
            ack_s1_q <= d;
            ack_s_q  <= ack_s1_q;
        end
    end

    assign q = ack_s_q;

endmodule

// File: rtl/cdc_hs_tx_ctrl.sv
// rtl/cdc_hs_tx_ctrl.sv - source-side toggle handshake controller; CDC_HS_TIMEOUT_EN adds the WAIT timeout / ABORT path
module cdc_hs_tx_ctrl
    import cdc_hs_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [DATA_W-1:0]    xfer_data,
    output logic                 xfer_req,
    input  logic                 xfer_ack,
    output logic                 busy,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    output logic                 timeout_err,
    input  logic                 err_clr
);

    cdc_hs_state_t     state_q, state_d;
    logic              xfer_req_q, xfer_req_d;
    logic [DATA_W-1:0] xfer_data_q, xfer_data_d;
    logic              ack_s;
    logic              ack_match;

`ifdef CDC_HS_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] CNT_ONE = TIMEOUT_W'(1);
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 timeout_err_q, timeout_err_d;
    logic                 timeout_hit;
`else
    logic unused_timeout_inputs;
    assign unused_timeout_inputs = ^{timeout_cycles, err_clr};
`endif

    cdc_hs_ack_sync u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (xfer_ack),
        .q   (ack_s)
    );

    // Transfer is complete once the synchronized ack has caught up with our request phase
    assign ack_match = (ack_s == xfer_req_q);

`ifdef CDC_HS_TIMEOUT_EN
    assign timeout_hit = (timeout_cycles != '0) && (cnt_q == timeout_cycles - CNT_ONE);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        xfer_req_d  = xfer_req_q;
        xfer_data_d = xfer_data_q;
`ifdef CDC_HS_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
        if (err_clr) begin
            timeout_err_d = 1'b0;
        end
`endif
        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    xfer_data_d = s_data;
                    xfer_req_d  = ~xfer_req_q;
                    state_d     = WAIT;
`ifdef CDC_HS_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            WAIT: begin
`ifdef CDC_HS_TIMEOUT_EN
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
`endif
                if (ack_match) begin
                    state_d = IDLE;
`ifdef CDC_HS_TIMEOUT_EN
                end else if (timeout_hit) begin
                    timeout_err_d = 1'b1;
                    state_d       = ABORT;
`endif
                end
            end
            ABORT: begin
`ifdef CDC_HS_TIMEOUT_EN
                // Adopt the destination's phase so no spurious request edge is issued
                if (err_clr) begin
                    timeout_err_d = 1'b0;
                    xfer_req_d    = ack_s;
                    state_d       = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_req_q  <= 1'b0;
            xfer_data_q <= '0;
`ifdef CDC_HS_TIMEOUT_EN
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            xfer_req_q  <= xfer_req_d;
            xfer_data_q <= xfer_data_d;
`ifdef CDC_HS_TIMEOUT_EN
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    always_comb begin
        s_ready = 1'b0;
        busy    = 1'b0;
        case (state_q)
            IDLE:        s_ready = 1'b1;
            WAIT, ABORT: busy    = 1'b1;
            default:     s_ready = 1'b0;
        endcase
    end

    assign xfer_req  = xfer_req_q;
    assign xfer_data = xfer_data_q;
`ifdef CDC_HS_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_hs_tx_ctrl.sv
// tb/tb_cdc_hs_tx_ctrl.sv - bench for cdc_hs_tx_ctrl; timeout cases run when CDC_HS_TIMEOUT_EN is defined
module tb_cdc_hs_tx_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] xfer_data;
    logic        xfer_req;
    logic        xfer_ack;
    logic        busy;
    logic [15:0] timeout_cycles;
    logic        timeout_err;
    logic        err_clr;

    int total = 0;
    int bad   = 0;

    logic [31:0] rx_q[$];
    logic        dst_last;
    int          dst_cnt;
    int          dst_lat;
    bit          dst_rnd;
    int          dst_fixed;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [31:0] data;
        logic        ack;
        logic        e_rdy;
        logic        e_busy;
        logic        e_req;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[12];

    cdc_hs_tx_ctrl #(.DATA_W(32), .TIMEOUT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .xfer_data      (xfer_data),
        .xfer_req       (xfer_req),
        .xfer_ack       (xfer_ack),
        .busy           (busy),
        .timeout_cycles (timeout_cycles),
        .timeout_err    (timeout_err),
        .err_clr        (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string nm, input logic act, input logic want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %b expected %b", nm, act, want);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        s_valid        = 1'b0;
        s_data         = '0;
        xfer_ack       = 1'b0;
        err_clr        = 1'b0;
        timeout_cycles = '0;
        @(posedge clk); #1;
        rst      = 1'b0;
        dst_last = 1'b0;
        dst_cnt  = -1;
        dst_lat  = -1;
        rx_q.delete();
    endtask

    task automatic accept_word(input logic [31:0] w);
        s_valid = 1'b1;
        s_data  = w;
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    // Destination-side model, stepped once per falling edge: captures each request, echoes it after a delay
    task automatic dst_step();
        if (dst_lat >= 0) begin
            dst_lat++;
            if (dst_lat < 3) begin
                chk1("ack_to_ready_early", s_ready, 1'b0);
            end else begin
                chk1("ack_to_ready", s_ready, 1'b1);
                dst_lat = -1;
            end
        end
        if (dst_cnt > 0) dst_cnt--;
        if (xfer_req !== dst_last) begin
            dst_last = xfer_req;
            rx_q.push_back(xfer_data);
            dst_cnt = dst_rnd ? int'($urandom_range(0, 6)) : dst_fixed;
        end else if (busy && rx_q.size() != 0) begin
            chk32("data_hold", xfer_data, rx_q[rx_q.size()-1]);
        end
        if (dst_cnt == 0) begin
            xfer_ack = dst_last;
            dst_cnt  = -1;
            dst_lat  = 0;
        end
    endtask

    task automatic run_stream(input int n, input bit rnd, input int fixed_delay);
        logic [31:0] tx[$];
        int  idx;
        int  gap;
        bit  acc;
        bit  done;
        for (int i = 0; i < n; i++) tx.push_back($urandom);
        do_reset();
        dst_rnd   = rnd;
        dst_fixed = fixed_delay;
        idx  = 0;
        gap  = 0;
        acc  = 1'b0;
        done = 1'b0;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            @(negedge clk);
            dst_step();
            if (acc) begin
                idx++;
                s_valid = 1'b0;
                gap = rnd ? int'($urandom_range(0, 3)) : 0;
            end
            if (!s_valid && idx < n) begin
                if (gap > 0) gap--;
                else begin
                    s_valid = 1'b1;
                    s_data  = tx[idx];
                end
            end
            acc = s_valid && s_ready;
            if (idx == n && !busy && dst_cnt < 0 && dst_lat < 0) done = 1'b1;
        end
        chk1("stream_completes", done, 1'b1);
        chk32("stream_count", 32'(rx_q.size()), 32'(n));
        for (int i = 0; i < n && i < rx_q.size(); i++) begin
            chk32($sformatf("stream_word%0d", i), rx_q[i], tx[i]);
        end
        s_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA5A5_0001};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'hA5A5_0001};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b1, 32'hA5A5_0001};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b1, 32'hA5A5_0001};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 32'hA5A5_0001};
        vecs[6]  = '{1'b0, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1234_5678};
        vecs[7]  = '{1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1234_5678};
        vecs[8]  = '{1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234_5678};
        vecs[9]  = '{1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234_5678};
        vecs[10] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h1234_5678};
        vecs[11] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h1234_5678};

        dst_rnd   = 1'b0;
        dst_fixed = 0;
        do_reset();

        for (int i = 0; i < 12; i++) begin
            rst      = vecs[i].rst;
            s_valid  = vecs[i].vld;
            s_data   = vecs[i].data;
            xfer_ack = vecs[i].ack;
            @(posedge clk); #1;
            chk1($sformatf("vec%0d_ready", i), s_ready, vecs[i].e_rdy);
            chk1($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            chk1($sformatf("vec%0d_req", i), xfer_req, vecs[i].e_req);
            chk32($sformatf("vec%0d_data", i), xfer_data, vecs[i].e_data);
            chk1($sformatf("vec%0d_err", i), timeout_err, 1'b0);
        end
        rst     = 1'b0;
        s_valid = 1'b0;

        run_stream(4, 1'b0, 5);
        run_stream(24, 1'b1, 0);

        // Reset in the middle of WAIT drops the transfer
        do_reset();
        accept_word(32'hCAFE_0042);
        chk1("midwait_busy", busy, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk1("midwait_ready", s_ready, 1'b1);
        chk1("midwait_busy0", busy, 1'b0);
        chk1("midwait_req", xfer_req, 1'b0);
        chk32("midwait_data", xfer_data, 32'h0);
        chk1("midwait_err", timeout_err, 1'b0);

        // Long stall with the timeout disabled (or compiled out) never errors
        do_reset();
`ifdef CDC_HS_TIMEOUT_EN
        timeout_cycles = 16'd0;
`else
        timeout_cycles = 16'd3;
`endif
        accept_word(32'h0000_0100);
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            chk1("stall_err", timeout_err, 1'b0);
            chk1("stall_busy", busy, 1'b1);
        end
        xfer_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk1("late_ack_ready", s_ready, 1'b1);
        chk1("late_ack_busy", busy, 1'b0);
        chk1("late_ack_err", timeout_err, 1'b0);

`ifdef CDC_HS_TIMEOUT_EN
        // Timeout: error exactly T cycles after WAIT entry, then clear and realign
        do_reset();
        timeout_cycles = 16'd10;
        accept_word(32'h0BAD_0010);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            chk1($sformatf("to_err_k%0d", k), timeout_err, k == 10);
            chk1("to_busy", busy, 1'b1);
            chk1("to_ready", s_ready, 1'b0);
        end
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk1("clr_err", timeout_err, 1'b0);
        chk1("clr_realign", xfer_req, 1'b0);
        chk1("clr_ready", s_ready, 1'b1);
        accept_word(32'h0BAD_0011);
        chk1("post_abort_req", xfer_req, 1'b1);
        xfer_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk1("post_abort_done", s_ready, 1'b1);

        // Ack match landing on the timeout cycle wins
        do_reset();
        timeout_cycles = 16'd6;
        accept_word(32'h0000_0600);
        repeat (3) @(posedge clk);
        #1;
        xfer_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk1("race_pre_busy", busy, 1'b1);
        @(posedge clk); #1;
        chk1("race_err", timeout_err, 1'b0);
        chk1("race_ready", s_ready, 1'b1);
        chk1("race_busy", busy, 1'b0);

        // One cycle later the ack loses; realign picks up the now-synchronized ack
        do_reset();
        timeout_cycles = 16'd6;
        accept_word(32'h0000_0601);
        repeat (4) @(posedge clk);
        #1;
        xfer_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk1("late_race_err", timeout_err, 1'b1);
        chk1("late_race_busy", busy, 1'b1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk1("late_race_realign", xfer_req, 1'b1);
        chk1("late_race_ready", s_ready, 1'b1);
        chk1("late_race_clr", timeout_err, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
